// File: rtl/i3c_fifo_regs.sv
// APB register block for an I3C controller: TX/RX data FIFOs, thresholds and interrupt status.
// The bus side pops TX with tb_rd and pushes RX with fb_wr; software uses WDATA/RDATA.
module i3c_fifo_regs #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENA,
    input  logic              PWRITE,
    input  logic [11:2]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    input  logic              tb_rd,
    output logic [DATA_W-1:0] tb_data,
    output logic              tb_empty,
    input  logic              fb_wr,
    input  logic [DATA_W-1:0] fb_data,
    output logic              fb_full,
    output logic              irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int Q  = FIFO_DEPTH / 4;

    localparam logic [9:0] A_CTRL  = 10'h000;
    localparam logic [9:0] A_STAT  = 10'h001;
    localparam logic [9:0] A_INTST = 10'h002;
    localparam logic [9:0] A_INTEN = 10'h003;
    localparam logic [9:0] A_WDATA = 10'h004;
    localparam logic [9:0] A_RDATA = 10'h005;

    logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
    logic [1:0]        r_tx_trig, r_rx_trig;
    logic [3:0]        r_inten;
    logic              r_tx_ovf, r_rx_unf;

    logic w_wr, w_rd, w_tx_full, w_rx_empty;
    logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_flush;
    logic w_rx_rd, w_rx_push, w_rx_pop, w_rx_flush;
    logic w_tx_rdy, w_rx_pend;
    logic [3:0]  w_intstat;
    logic [31:0] w_rdata;
    logic [CW+1:0] w_tx_thr, w_rx_thr;

    assign w_wr = PSEL & PENA & PWRITE;
    assign w_rd = PSEL & PENA & ~PWRITE;

    assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign tb_empty   = (r_tx_cnt == '0);
    assign fb_full    = (r_rx_cnt == CW'(FIFO_DEPTH));

    assign w_tx_flush = w_wr & (PADDR == A_CTRL) & PWDATA[0];
    assign w_rx_flush = w_wr & (PADDR == A_CTRL) & PWDATA[1];
    assign w_tx_wr    = w_wr & (PADDR == A_WDATA);
    assign w_rx_rd    = w_rd & (PADDR == A_RDATA);

    // A full TX FIFO still accepts a push when the bus pops in the same cycle
    assign w_tx_pop  = tb_rd & ~tb_empty;
    assign w_tx_push = w_tx_wr & (~w_tx_full | w_tx_pop);
    assign w_rx_pop  = w_rx_rd & ~w_rx_empty;
    assign w_rx_push = fb_wr & ~fb_full;

    assign w_tx_thr  = (CW+2)'(Q) * (CW+2)'(r_tx_trig);
    assign w_rx_thr  = (CW+2)'(Q) * (CW+2)'(r_rx_trig);
    assign w_tx_rdy  = ({2'b00, r_tx_cnt} <= w_tx_thr);
    assign w_rx_pend = ({2'b00, r_rx_cnt} >  w_rx_thr);
    assign w_intstat = {r_rx_unf, r_tx_ovf, w_rx_pend, w_tx_rdy};

    assign irq     = |(w_intstat & r_inten);
    assign PREADY  = 1'b1;
    assign tb_data = tb_empty ? '0 : r_tx_mem[r_tx_rp];

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (PADDR)
                A_CTRL:  w_rdata[7:4] = {r_rx_trig, r_tx_trig};
                A_STAT: begin
                    w_rdata[CW-1:0] = r_tx_cnt;
                    w_rdata[CW+7:8] = r_rx_cnt;
                    w_rdata[16]     = w_tx_full;
                    w_rdata[17]     = w_rx_empty;
                end
                A_INTST: w_rdata[3:0] = w_intstat;
                A_INTEN: w_rdata[3:0] = r_inten;
                A_RDATA: w_rdata[DATA_W-1:0] = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
                default: w_rdata = '0;
            endcase
        end
    end
    assign PRDATA = PRESETn ? w_rdata : '0;

    // Storage is deliberately unreset; heads are masked while empty
    always_ff @(posedge PCLK) begin
        if (w_tx_push && !w_tx_flush) r_tx_mem[r_tx_wp] <= PWDATA[DATA_W-1:0];
        if (w_rx_push && !w_rx_flush) r_rx_mem[r_rx_wp] <= fb_data;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else if (w_rx_flush) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    // Error flags: a new event in the same cycle as a W1C keeps the flag set
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx_trig <= '0;
            r_rx_trig <= '0;
            r_inten   <= '0;
            r_tx_ovf  <= 1'b0;
            r_rx_unf  <= 1'b0;
        end else begin
            if (w_wr && PADDR == A_CTRL) begin
                r_tx_trig <= PWDATA[5:4];
                r_rx_trig <= PWDATA[7:6];
            end
            if (w_wr && PADDR == A_INTEN) r_inten <= PWDATA[3:0];
            r_tx_ovf <= (r_tx_ovf & ~(w_wr && PADDR == A_INTST && PWDATA[2]))
                      | (w_tx_wr & w_tx_full & ~w_tx_pop);
            r_rx_unf <= (r_rx_unf & ~(w_wr && PADDR == A_INTST && PWDATA[3]))
                      | (w_rx_rd & w_rx_empty);
        end
    end
endmodule

// File: tb/tb_i3c_fifo_regs.sv
// Directed bench for i3c_fifo_regs at FIFO_DEPTH=8, DATA_W=8.
module tb_i3c_fifo_regs;
    logic        PCLK, PRESETn, PSEL, PENA, PWRITE;
    logic [11:2] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY;
    logic        tb_rd, tb_empty, fb_wr, fb_full, irq;
    logic [7:0]  tb_data, fb_data;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [11:0] CTRL = 12'h000, STAT = 12'h004, INTST = 12'h008,
                            INTEN = 12'h00C, WDATA = 12'h010, RDATA = 12'h014;

    i3c_fifo_regs #(.FIFO_DEPTH(8), .DATA_W(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENA(PENA), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .tb_rd(tb_rd), .tb_data(tb_data), .tb_empty(tb_empty),
        .fb_wr(fb_wr), .fb_data(fb_data), .fb_full(fb_full), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1; PENA = 1; PWRITE = 1; PADDR = a[11:2]; PWDATA = d;
        @(negedge PCLK);
        PSEL = 0; PENA = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1; PENA = 1; PWRITE = 0; PADDR = a[11:2];
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 0; PENA = 0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge PCLK);
        fb_wr = 1; fb_data = d;
        @(negedge PCLK);
        fb_wr = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge PCLK);
        PSEL = 1; PENA = 1; PWRITE = 0; PADDR = STAT[11:2];
        #1;
        n_chk++; if (PRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_prdata got %h exp 0", PRDATA); end
        n_chk++; if ({tb_empty, fb_full, irq} !== 3'b100) begin n_fail++; $display("FAIL rst_flags got %b exp 100", {tb_empty, fb_full, irq}); end
        n_chk++; if (tb_data !== 8'h00) begin n_fail++; $display("FAIL rst_tb_data got %h exp 0", tb_data); end
        @(negedge PCLK);
        PSEL = 0; PENA = 0; PRESETn = 1;
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL rst_intstat got %h exp 1", d); end
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL rst_status got %h exp 20000", d); end
    endtask

    task automatic test_tx_ovf();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) apb_write(WDATA, 32'hA1 + i);
        apb_write(WDATA, 32'hFF);
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0003_0008) begin n_fail++; $display("FAIL ovf_status got %h exp 30008", d); end
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovf_intstat got %h exp 4", d); end
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            n_chk++; if (tb_data !== 8'(8'hA1 + i)) begin n_fail++; $display("FAIL ovf_pop%0d got %h exp %h", i, tb_data, 8'(8'hA1 + i)); end
            tb_rd = 1;
            @(negedge PCLK);
            tb_rd = 0;
        end
        n_chk++; if (tb_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b exp 1", tb_empty); end
        apb_write(INTST, 32'h4);
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL ovf_clear got %h exp 1", d); end
    endtask

    task automatic test_rx_unf();
        logic [31:0] d;
        logic [31:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h0;
        rx_push(8'h11);
        rx_push(8'h22);
        for (int i = 0; i < 3; i++) begin
            apb_read(RDATA, d);
            n_chk++; if (d !== exp[i]) begin n_fail++; $display("FAIL unf_rd%0d got %h exp %h", i, d, exp[i]); end
        end
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h9) begin n_fail++; $display("FAIL unf_intstat got %h exp 9", d); end
        apb_write(INTST, 32'h8);
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL unf_clear got %h exp 1", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        apb_write(INTEN, 32'h2);
        apb_write(CTRL, 32'h80);
        for (int i = 0; i < 4; i++) rx_push(8'h61 + 8'(i));
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_at4 got %b exp 0", irq); end
        @(negedge PCLK);
        fb_wr = 1; fb_data = 8'h65;
        #1;
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_edge got %b exp 0", irq); end
        @(negedge PCLK);
        fb_wr = 0;
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_at5 got %b exp 1", irq); end
        apb_read(RDATA, d);
        n_chk++; if (d !== 32'h61) begin n_fail++; $display("FAIL irq_rd got %h exp 61", d); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_rd got %b exp 0", irq); end
        for (int i = 1; i < 5; i++) begin
            apb_read(RDATA, d);
            n_chk++; if (d !== 32'h61 + i) begin n_fail++; $display("FAIL irq_drain%0d got %h exp %h", i, d, 32'h61 + i); end
        end
        apb_write(INTEN, 32'h0);
        apb_write(CTRL, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) apb_write(WDATA, 32'hB0 + i);
        @(negedge PCLK);
        PSEL = 1; PENA = 1; PWRITE = 1; PADDR = WDATA[11:2]; PWDATA = 32'h5A; tb_rd = 1;
        #1;
        n_chk++; if (tb_data !== 8'hB0) begin n_fail++; $display("FAIL b2b_head got %h exp b0", tb_data); end
        @(negedge PCLK);
        PSEL = 0; PENA = 0; PWRITE = 0; tb_rd = 0;
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0003_0008) begin n_fail++; $display("FAIL b2b_status got %h exp 30008", d); end
        apb_read(INTST, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_intstat got %h exp 0", d); end
        for (int i = 1; i < 9; i++) begin
            logic [7:0] e;
            e = (i == 8) ? 8'h5A : 8'(8'hB0 + i);
            @(negedge PCLK);
            n_chk++; if (tb_data !== e) begin n_fail++; $display("FAIL b2b_pop%0d got %h exp %h", i, tb_data, e); end
            tb_rd = 1;
            @(negedge PCLK);
            tb_rd = 0;
        end
        n_chk++; if (tb_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b exp 1", tb_empty); end
    endtask

    task automatic test_wrap_flush();
        logic [31:0] d;
        for (int i = 0; i < 20; i++) begin
            rx_push(8'h30 + 8'(i));
            apb_read(RDATA, d);
            n_chk++; if (d !== 32'h30 + i) begin n_fail++; $display("FAIL wrap%0d got %h exp %h", i, d, 32'h30 + i); end
        end
        for (int i = 0; i < 3; i++) rx_push(8'hC0 + 8'(i));
        @(negedge PCLK);
        PSEL = 1; PENA = 1; PWRITE = 1; PADDR = CTRL[11:2]; PWDATA = 32'h2;
        fb_wr = 1; fb_data = 8'hEE;
        @(negedge PCLK);
        PSEL = 0; PENA = 0; PWRITE = 0; fb_wr = 0;
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL flush_status got %h exp 20000", d); end
        apb_read(CTRL, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL flush_ctrl got %h exp 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        apb_write(CTRL, 32'h31);
        apb_read(CTRL, d);
        n_chk++; if (d !== 32'h30) begin n_fail++; $display("FAIL mid_ctrl got %h exp 30", d); end
        apb_write(INTEN, 32'hF);
        for (int i = 0; i < 5; i++) apb_write(WDATA, 32'h70 + i);
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0002_0005) begin n_fail++; $display("FAIL mid_status got %h exp 20005", d); end
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq got %b exp 1", irq); end
        @(negedge PCLK);
        PRESETn = 0;
        #2;
        n_chk++; if ({tb_empty, irq} !== 2'b10) begin n_fail++; $display("FAIL mid_rst got %b exp 10", {tb_empty, irq}); end
        @(negedge PCLK);
        PRESETn = 1;
        apb_read(STAT, d);
        n_chk++; if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL mid_status2 got %h exp 20000", d); end
        apb_read(CTRL, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl2 got %h exp 0", d); end
        apb_read(INTEN, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_inten2 got %h exp 0", d); end
    endtask

    initial begin
        PRESETn = 0; PSEL = 0; PENA = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        tb_rd = 0; fb_wr = 0; fb_data = '0;
        test_reset();
        test_tx_ovf();
        test_rx_unf();
        test_irq();
        test_back_to_back();
        test_wrap_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
